// File: rtl/uart_irq_ctrl_pkg.sv
// Shared constants for the UART interrupt controller: default sizing, IIR encodings, source indices.
// Combinational constants only; no latency, no backpressure.
package uart_irq_ctrl_pkg;

  localparam int DEF_NUM_SRC   = 5;
  localparam int DEF_ID_W      = 3;
  localparam int DEF_HOLDOFF_W = 8;

  // Only THRE clears on an IIR read, matching the classic 16550.
  localparam logic [DEF_NUM_SRC-1:0] DEF_CLR_ON_IIR = 5'b01000;

  localparam logic IIR_IP_NONE = 1'b1;

  typedef enum logic [2:0] {
    SRC_RLS  = 3'd0,
    SRC_RDA  = 3'd1,
    SRC_CTI  = 3'd2,
    SRC_THRE = 3'd3,
    SRC_MS   = 3'd4
  } src_idx_e;

endpackage

// File: rtl/uart_irq_ctrl_if.sv
// Register-file side bundle of the interrupt controller: sources, enables, strobes and IIR/int outputs.
// Wires only; no latency, strobes are single-cycle with no backpressure.
interface uart_irq_ctrl_if
  import uart_irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int ID_W      = DEF_ID_W,
  parameter int HOLDOFF_W = DEF_HOLDOFF_W
);

  logic [NUM_SRC-1:0]   src_i;
  logic [NUM_SRC-1:0]   ier_i;
  logic [NUM_SRC-1:0]   edge_mode_i;
  logic [NUM_SRC-1:0]   src_clr_i;
  logic                 iir_read_i;
  logic [HOLDOFF_W-1:0] holdoff_i;
  logic [NUM_SRC-1:0]   pnd_o;
  logic [ID_W-1:0]      iir_id_o;
  logic                 iir_ip_o;
  logic                 int_o;

  modport master (
    output src_i, ier_i, edge_mode_i, src_clr_i, iir_read_i, holdoff_i,
    input  pnd_o, iir_id_o, iir_ip_o, int_o
  );

  modport slave (
    input  src_i, ier_i, edge_mode_i, src_clr_i, iir_read_i, holdoff_i,
    output pnd_o, iir_id_o, iir_ip_o, int_o
  );

endinterface

// File: rtl/uart_irq_src.sv
// One interrupt source: input delay, rise detect and the pending flop (edge-latched or level).
// Pending updates on the same edge that samples the source; no backpressure.
module uart_irq_src (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic src,
  input  logic ier,
  input  logic edge_mode,
  input  logic src_clr,
  input  logic iir_clr,
  output logic pnd
);

  logic src_d;
  logic rise;

  assign rise = src & ~src_d;

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      src_d <= 1'b0;
      pnd   <= 1'b0;
    end else begin
      src_d <= src;
      if (edge_mode) begin
        // A fresh edge wins over any clear in the same cycle so no event is lost.
        if (rise)
          pnd <= 1'b1;
        else if (src_clr | iir_clr)
          pnd <= 1'b0;
        else
          pnd <= pnd & ier;
      end else begin
        pnd <= src & ier;
      end
    end
  end

endmodule

// File: rtl/uart_irq_ctrl.sv
// NUM_SRC-source interrupt pending/priority controller with IIR registers and an int_o holdoff timer.
// pnd_o one edge after the source, IIR/int_o one edge after pnd_o; strobes are never backpressured.
module uart_irq_ctrl
  import uart_irq_ctrl_pkg::*;
#(
  parameter int                 NUM_SRC    = DEF_NUM_SRC,
  parameter int                 ID_W       = DEF_ID_W,
  parameter int                 HOLDOFF_W  = DEF_HOLDOFF_W,
  parameter logic [NUM_SRC-1:0] CLR_ON_IIR = NUM_SRC'(DEF_CLR_ON_IIR)
) (
  input  logic            clk,
  input  logic            wb_rst_i,
  uart_irq_ctrl_if.slave  irq
);

  logic [NUM_SRC-1:0]   pnd;
  logic [NUM_SRC-1:0]   iir_clr;
  logic [NUM_SRC-1:0]   mp;
  logic [ID_W-1:0]      id;
  logic                 any;
  logic                 int_nxt;
  logic [ID_W-1:0]      iir_id_q;
  logic                 iir_ip_q;
  logic                 int_q;
  logic [HOLDOFF_W-1:0] hcnt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    // Uses the registered IIR so only the source the CPU actually sees is cleared.
    assign iir_clr[g] = irq.iir_read_i & CLR_ON_IIR[g] & ~iir_ip_q & (iir_id_q == ID_W'(g));

    uart_irq_src u_src (
      .clk       (clk),
      .wb_rst_i  (wb_rst_i),
      .src       (irq.src_i[g]),
      .ier       (irq.ier_i[g]),
      .edge_mode (irq.edge_mode_i[g]),
      .src_clr   (irq.src_clr_i[g]),
      .iir_clr   (iir_clr[g]),
      .pnd       (pnd[g])
    );
  end

  assign mp = pnd & irq.ier_i;

  always_comb begin
    id  = '0;
    any = |mp;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (mp[i])
        id = ID_W'(i);
    end
  end

  assign int_nxt = any & (hcnt == '0);

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      iir_id_q <= '0;
      iir_ip_q <= IIR_IP_NONE;
      int_q    <= 1'b0;
      hcnt     <= '0;
    end else begin
      iir_id_q <= any ? id : '0;
      iir_ip_q <= ~any;
      int_q    <= int_nxt;
      // holdoff_i is only sampled on the falling edge of int_o.
      if (int_q && !int_nxt)
        hcnt <= irq.holdoff_i;
      else if (hcnt != '0)
        hcnt <= hcnt - 1'b1;
    end
  end

  assign irq.pnd_o    = pnd;
  assign irq.iir_id_o = iir_id_q;
  assign irq.iir_ip_o = iir_ip_q;
  assign irq.int_o    = int_q;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Bench for uart_irq_ctrl: directed vector table, hand-written corner sequences, then random traffic
// compared every cycle against a rule-level reference model.
module tb_uart_irq_ctrl;
  import uart_irq_ctrl_pkg::*;

  localparam int         NS = 5;
  localparam int         IW = 3;
  localparam int         HW = 8;
  localparam logic [4:0] CLR_MASK = 5'b01000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_irq_ctrl_if #(.NUM_SRC(NS), .ID_W(IW), .HOLDOFF_W(HW)) bus ();

  uart_irq_ctrl #(
    .NUM_SRC(NS), .ID_W(IW), .HOLDOFF_W(HW), .CLR_ON_IIR(CLR_MASK)
  ) dut (
    .clk      (clk),
    .wb_rst_i (rst),
    .irq      (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model state, advanced from the behavioural rules at each rising edge.
  logic [4:0] m_src_d, m_pnd;
  int         m_id, m_hcnt;
  bit         m_ip, m_int;

  task automatic model_step();
    logic [4:0] mp, np;
    int  id;
    bit  any, nint;
    if (rst) begin
      m_src_d = '0; m_pnd = '0; m_id = 0; m_ip = 1'b1; m_int = 1'b0; m_hcnt = 0;
      return;
    end
    mp  = m_pnd & bus.ier_i;
    any = 1'b0;
    id  = 0;
    for (int i = 0; i < NS; i++)
      if (mp[i] && !any) begin any = 1'b1; id = i; end
    np = '0;
    for (int i = 0; i < NS; i++) begin
      bit rise, ic;
      rise = bus.src_i[i] && !m_src_d[i];
      ic   = bus.iir_read_i && CLR_MASK[i] && !m_ip && (m_id == i);
      if (bus.edge_mode_i[i])
        np[i] = rise ? 1'b1 : ((bus.src_clr_i[i] || ic) ? 1'b0 : (m_pnd[i] && bus.ier_i[i]));
      else
        np[i] = bus.src_i[i] && bus.ier_i[i];
    end
    nint = any && (m_hcnt == 0);
    if (m_int && !nint) m_hcnt = int'(bus.holdoff_i);
    else if (m_hcnt > 0) m_hcnt--;
    m_int   = nint;
    m_ip    = !any;
    m_id    = id;
    m_pnd   = np;
    m_src_d = bus.src_i;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] src;
    logic [4:0] clr;
    logic       rd;
    logic [4:0] e_pnd;
    int         e_id;
    logic       e_ip;
    logic       e_int;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic [4:0] s, logic [4:0] c, logic rd,
                              logic [4:0] p, int id, logic ip, logic it);
    vec_t v;
    v.rst = r; v.src = s; v.clr = c; v.rd = rd;
    v.e_pnd = p; v.e_id = id; v.e_ip = ip; v.e_int = it;
    return v;
  endfunction

  int k;

  initial begin
    rst = 1'b1;
    bus.src_i = '0; bus.ier_i = 5'h1F; bus.edge_mode_i = 5'h1F;
    bus.src_clr_i = '0; bus.iir_read_i = 1'b0; bus.holdoff_i = '0;

    // reset held with all sources high, then release and walk the priority / clear cases
    for (int i = 0; i < 3; i++) vt.push_back(mk(1, 5'h1F, 5'h00, 0, 5'h00, 0, 1, 0));
    vt.push_back(mk(0, 5'h1F, 5'h00, 0, 5'h1F, 0, 1, 0));
    vt.push_back(mk(0, 5'h1F, 5'h00, 0, 5'h1F, 0, 0, 1));
    vt.push_back(mk(0, 5'h00, 5'h1F, 0, 5'h00, 0, 0, 1));
    vt.push_back(mk(0, 5'h00, 5'h00, 0, 5'h00, 0, 1, 0));
    vt.push_back(mk(0, 5'h0A, 5'h00, 0, 5'h0A, 0, 1, 0));
    vt.push_back(mk(0, 5'h0A, 5'h00, 0, 5'h0A, 1, 0, 1));
    vt.push_back(mk(0, 5'h0A, 5'h02, 0, 5'h08, 1, 0, 1));
    vt.push_back(mk(0, 5'h0A, 5'h00, 0, 5'h08, 3, 0, 1));
    vt.push_back(mk(0, 5'h0A, 5'h08, 0, 5'h00, 3, 0, 1));
    vt.push_back(mk(0, 5'h0A, 5'h00, 0, 5'h00, 0, 1, 0));
    vt.push_back(mk(0, 5'h00, 5'h00, 0, 5'h00, 0, 1, 0));
    vt.push_back(mk(0, 5'h08, 5'h00, 0, 5'h08, 0, 1, 0));
    vt.push_back(mk(0, 5'h08, 5'h00, 0, 5'h08, 3, 0, 1));
    vt.push_back(mk(0, 5'h08, 5'h00, 1, 5'h00, 3, 0, 1));
    vt.push_back(mk(0, 5'h08, 5'h00, 0, 5'h00, 0, 1, 0));
    vt.push_back(mk(0, 5'h02, 5'h00, 0, 5'h02, 0, 1, 0));
    vt.push_back(mk(0, 5'h02, 5'h00, 0, 5'h02, 1, 0, 1));
    vt.push_back(mk(0, 5'h02, 5'h00, 1, 5'h02, 1, 0, 1));
    vt.push_back(mk(0, 5'h02, 5'h02, 0, 5'h00, 1, 0, 1));
    vt.push_back(mk(0, 5'h02, 5'h00, 0, 5'h00, 0, 1, 0));
    vt.push_back(mk(0, 5'h04, 5'h04, 0, 5'h04, 0, 1, 0));
    vt.push_back(mk(0, 5'h04, 5'h00, 0, 5'h04, 2, 0, 1));
    vt.push_back(mk(0, 5'h04, 5'h04, 0, 5'h00, 2, 0, 1));
    vt.push_back(mk(0, 5'h04, 5'h00, 0, 5'h00, 0, 1, 0));

    foreach (vt[r]) begin
      rst = vt[r].rst; bus.src_i = vt[r].src; bus.src_clr_i = vt[r].clr; bus.iir_read_i = vt[r].rd;
      step();
      chk($sformatf("vec%0d_pnd", r), 32'(bus.pnd_o),    32'(vt[r].e_pnd));
      chk($sformatf("vec%0d_id",  r), 32'(bus.iir_id_o), 32'(vt[r].e_id));
      chk($sformatf("vec%0d_ip",  r), 32'(bus.iir_ip_o), 32'(vt[r].e_ip));
      chk($sformatf("vec%0d_int", r), 32'(bus.int_o),    32'(vt[r].e_int));
    end
    bus.src_clr_i = '0; bus.iir_read_i = 1'b0;

    // level mode on source 0: clear strobes are ignored while the condition holds
    bus.edge_mode_i = 5'h1E; bus.src_i = 5'h05;
    step();
    chk("lvl_pnd", 32'(bus.pnd_o), 32'h01);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      bus.src_clr_i = (c == 4) ? 5'h01 : 5'h00;
      step();
      if (bus.int_o === 1'b1) k++;
    end
    bus.src_clr_i = '0;
    chk("lvl_hold", 32'(k), 32'd10);
    bus.src_i = 5'h04;
    step();
    chk("lvl_drop_1", 32'(bus.int_o), 32'd1);
    step();
    chk("lvl_drop_2", 32'(bus.int_o), 32'd0);

    // edge on a disabled source: one-cycle pending, never an interrupt
    bus.edge_mode_i = 5'h1F; bus.ier_i = 5'h0F; bus.src_i = 5'h14;
    step();
    chk("dis_pnd_1", 32'(bus.pnd_o), 32'h10);
    chk("dis_int_1", 32'(bus.int_o), 32'd0);
    step();
    chk("dis_pnd_2", 32'(bus.pnd_o), 32'h00);
    chk("dis_int_2", 32'(bus.int_o), 32'd0);
    bus.ier_i = 5'h1F; bus.src_i = 5'h04;

    // holdoff of 4: int_o reasserts on the 5th edge after the one where it fell
    bus.holdoff_i = 8'd4; bus.src_i = 5'h0C;
    step(); step();
    chk("ho_int_on", 32'(bus.int_o), 32'd1);
    bus.src_clr_i = 5'h08; bus.src_i = 5'h04;
    step();
    bus.src_clr_i = 5'h00; bus.src_i = 5'h0C;
    step();
    chk("ho_fall", 32'(bus.int_o), 32'd0);
    k = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      k++;
      bus.holdoff_i = 8'd9;
      if (bus.int_o === 1'b1) break;
    end
    chk("ho_len", 32'(k), 32'd5);

    // holdoff of 0: reassert on the edge right after the re-raise
    bus.holdoff_i = 8'd0;
    bus.src_clr_i = 5'h08; bus.src_i = 5'h04;
    step();
    bus.src_clr_i = 5'h00; bus.src_i = 5'h0C;
    step();
    chk("ho0_fall", 32'(bus.int_o), 32'd0);
    step();
    chk("ho0_back", 32'(bus.int_o), 32'd1);

    // reset while an interrupt is pending
    rst = 1'b1;
    step();
    chk("rst_mid", {bus.pnd_o, 1'b0, bus.iir_id_o, bus.iir_ip_o, bus.int_o}, {5'h00, 1'b0, 3'd0, 1'b1, 1'b0});
    rst = 1'b0;

    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 3) == 0) bus.src_i[i] = ~bus.src_i[i];
      bus.src_clr_i  = 5'($urandom) & 5'($urandom) & 5'($urandom);
      bus.iir_read_i = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) bus.ier_i = ($urandom_range(0, 1) != 0) ? 5'h1F : 5'($urandom);
      if ($urandom_range(0, 31) == 0) bus.edge_mode_i = 5'($urandom);
      if ($urandom_range(0, 15) == 0) bus.holdoff_i = 8'($urandom_range(0, 5));
      step();
      chk($sformatf("rnd%0d_pnd", c), 32'(bus.pnd_o),    32'(m_pnd));
      chk($sformatf("rnd%0d_id",  c), 32'(bus.iir_id_o), 32'(m_id));
      chk($sformatf("rnd%0d_ip",  c), 32'(bus.iir_ip_o), 32'(m_ip));
      chk($sformatf("rnd%0d_int", c), 32'(bus.int_o),    32'(m_int));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
